// File: rtl/srl_fifo_pkg.sv
// Shared definitions for the SRL FIFO slice.
//   - fifo_state_t : control state derived from the occupancy count
//   - clog2        : constant ceil(log2) helper
//   - count_width  : occupancy counter width for a given read-address width
//   - params_ok    : parameter legality (DEPTH 2..64, ADDR_WIDTH, thresholds)
package srl_fifo_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } fifo_state_t;

  localparam int unsigned MIN_DEPTH = 2;
  localparam int unsigned MAX_DEPTH = 64;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned rem;
    res = 0;
    rem = (value > 0) ? value - 1 : 0;
    while (rem > 0) begin
      res++;
      rem = rem >> 1;
    end
    return res;
  endfunction

  // Occupancy must represent 0..DEPTH, one bit wider than the read address.
  function automatic int unsigned count_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

  function automatic bit params_ok(input int unsigned depth,
                                   input int unsigned addr_width,
                                   input int unsigned afull_th,
                                   input int unsigned aempty_th);
    return (depth >= MIN_DEPTH) && (depth <= MAX_DEPTH) &&
           (addr_width == clog2(depth)) &&
           (afull_th >= 1) && (afull_th <= depth) &&
           (aempty_th <= depth - 1);
  endfunction

endpackage

// File: rtl/srl_fifo_param_store.sv
// Pure shift-register storage for the SRL FIFO. No reset so the array maps
// onto SRL primitives.
//   clk  : clock, rising edge
//   we   : shift enable; din enters slot 0, every entry moves up one
//   addr : read address
//   din  : write data
//   dout : combinational read of slot addr
module srl_fifo_param_store #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] sr [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      sr[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign dout = sr[addr];

endmodule

// File: rtl/srl_fifo_param.sv
// Parametrised SRL-based FIFO with show-ahead read data, registered
// full/empty/almost flags and occupancy output.
//   clk, reset (async, active-high; control state only)
//   if_write_ce, if_write, if_din  -> if_full_n, if_almost_full
//   if_read_ce, if_read            -> if_dout, if_empty_n, if_almost_empty
//   if_num_data_valid              : occupancy 0..DEPTH
// Optional macro SRL_FIFO_PARAM_ERR_CHECK_EN adds sticky err_overflow /
// err_underflow outputs plus simulation assertions on those events.
module srl_fifo_param
  import srl_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned AFULL_TH   = 14,
  parameter int unsigned AEMPTY_TH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  output logic                  if_almost_full,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic                  if_almost_empty,
  output logic [ADDR_WIDTH:0]   if_num_data_valid
`ifdef SRL_FIFO_PARAM_ERR_CHECK_EN
  ,
  output logic                  err_overflow,
  output logic                  err_underflow
`endif
);

  localparam int unsigned CW = count_width(ADDR_WIDTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  if (!params_ok(DEPTH, ADDR_WIDTH, AFULL_TH, AEMPTY_TH)) begin : g_bad_params
    $error("srl_fifo_param: illegal DEPTH/ADDR_WIDTH/threshold combination");
  end

  fifo_state_t           state, state_nxt;
  logic [CW-1:0]         count, count_nxt;
  logic [ADDR_WIDTH-1:0] rd_addr, rd_addr_nxt;
  logic                  push, pop;

  assign push = if_write & if_write_ce & (state != ST_FULL);
  assign pop  = if_read  & if_read_ce  & (state != ST_EMPTY);

  // Head sits at count-1; the address only moves while the FIFO is between
  // one and DEPTH entries, so it never wraps.
  always_comb begin
    count_nxt   = count;
    rd_addr_nxt = rd_addr;
    unique case ({push, pop})
      2'b10: begin
        count_nxt = count + ONE_C;
        if (count != '0) rd_addr_nxt = rd_addr + 1'b1;
      end
      2'b01: begin
        count_nxt = count - ONE_C;
        if (count != ONE_C) rd_addr_nxt = rd_addr - 1'b1;
      end
      default: ;
    endcase

    if (count_nxt == '0)          state_nxt = ST_EMPTY;
    else if (count_nxt == DEPTH_C) state_nxt = ST_FULL;
    else                           state_nxt = ST_PARTIAL;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= ST_EMPTY;
      count             <= '0;
      rd_addr           <= '0;
      if_full_n         <= 1'b1;
      if_empty_n        <= 1'b0;
      if_almost_full    <= 1'b0;
      if_almost_empty   <= 1'b1;
      if_num_data_valid <= '0;
    end else begin
      state             <= state_nxt;
      count             <= count_nxt;
      rd_addr           <= rd_addr_nxt;
      if_full_n         <= (state_nxt != ST_FULL);
      if_empty_n        <= (state_nxt != ST_EMPTY);
      if_almost_full    <= (count_nxt >= AFULL_C);
      if_almost_empty   <= (count_nxt <= AEMPTY_C);
      if_num_data_valid <= count_nxt;
    end
  end

  srl_fifo_param_store #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_store (
    .clk  (clk),
    .we   (push),
    .addr (rd_addr),
    .din  (if_din),
    .dout (if_dout)
  );

`ifdef SRL_FIFO_PARAM_ERR_CHECK_EN
  logic ovf_evt, udf_evt;
  assign ovf_evt = if_write & if_write_ce & ~if_full_n;
  assign udf_evt = if_read  & if_read_ce  & ~if_empty_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (ovf_evt) err_overflow  <= 1'b1;
      if (udf_evt) err_underflow <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !ovf_evt)
    else $error("srl_fifo_param: write while full");
  a_no_underflow: assert property (@(posedge clk) disable iff (reset) !udf_evt)
    else $error("srl_fifo_param: read while empty");
`endif
`endif

endmodule

// File: doc/srl_fifo_param.md
Name: srl_fifo_param

Overview:
- Parametrised SRL-based FIFO; next generation of the start/stream FIFOs between dataflow PEs in the Linear_Layer datapath.
- Adds to the plain shift-register store:
  - full/empty control with ce-qualified handshake,
  - occupancy output and programmable almost-full/almost-empty flags,
  - show-ahead read data.
- Sits between producer/consumer PE processes (e.g. PE_i4xi4 pack stages); DEPTH up to 64 (SRL-friendly).

Parameters:
- DATA_WIDTH, 32, payload width in bits.
- DEPTH, 16, capacity in entries; legal range 2..64.
- ADDR_WIDTH, 4, read-address width; must equal clog2(DEPTH).
- AFULL_TH, 14, if_almost_full asserted when count >= AFULL_TH; legal 1..DEPTH.
- AEMPTY_TH, 2, if_almost_empty asserted when count <= AEMPTY_TH; legal 0..DEPTH-1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_write_ce  in  1  write-side clock enable.
- if_write  in  1  write request.
- if_din  in  DATA_WIDTH  write data.
- if_full_n  out  1  high = space available.
- if_almost_full  out  1  count >= AFULL_TH.
- if_read_ce  in  1  read-side clock enable.
- if_read  in  1  read request (pop).
- if_dout  out  DATA_WIDTH  head-of-FIFO data (show-ahead).
- if_empty_n  out  1  high = if_dout valid.
- if_almost_empty  out  1  count <= AEMPTY_TH.
- if_num_data_valid  out  ADDR_WIDTH+1  current occupancy 0..DEPTH.

Behaviour:
- Clock/reset: one clock (clk); reset asynchronous, active-high, control state only.
- Reset values:
  - count=0, rd_addr=0, if_full_n=1, if_empty_n=0;
  - if_almost_empty=1 (0 <= AEMPTY_TH); if_almost_full=0; if_num_data_valid=0.
- SRL storage is not reset, so SRL inference is kept.
- Effective write: push = if_write & if_write_ce & if_full_n. Effective read: pop = if_read & if_read_ce & if_empty_n.
- Storage behaviour:
  - On push, all entries shift up one and din enters slot 0.
  - if_dout = SRL[rd_addr], combinational from the registered rd_addr; oldest entry sits at rd_addr = count-1.
- Control states (encoded by count):
  - EMPTY (count=0)
  - PARTIAL (0<count<DEPTH)
  - FULL (count=DEPTH)
- Transitions on the clock edge:
  - push only: count+1; rd_addr+1 unless count was 0 (rd_addr stays 0).
  - pop only: count-1; rd_addr-1 unless count becomes 0 (rd_addr stays 0).
  - push & pop: count and rd_addr unchanged; shift occurs, so the head advances correctly.
- Flag timing:
  - if_full_n, if_empty_n, the almost flags and if_num_data_valid are registered.
  - All update in the same edge as count (1-cycle latency from push to if_empty_n=1).
- Boundaries:
  - Write when full: ignored, no shift, no count change.
  - Read when empty: ignored.
  - In FULL, push & pop together: only pop is effective, because push needs if_full_n=1; result is count DEPTH-1.
  - In EMPTY, push & pop together: only push is effective.
- CE rule: if_write_ce=0 or if_read_ce=0 masks that side entirely.
- Reset mid-operation: control returns to EMPTY asynchronously; stale SRL data is never exposed, because if_empty_n=0.
- No wrap-around: rd_addr never leaves 0..DEPTH-1.

Optional Feature:
- Macro: SRL_FIFO_PARAM_ERR_CHECK_EN.
- When defined, adds two outputs, each 1 bit, sticky, cleared only by reset:
  - err_overflow: set on if_write & if_write_ce & !if_full_n.
  - err_underflow: set on if_read & if_read_ce & !if_empty_n.
- When defined, also adds a simulation-only assertion that fires on each such event.
- When undefined, these ports and the logic are absent, and the port list is exactly as above.

Decomposition:
- Shared package srl_fifo_pkg:
  - clog2 constant function;
  - count-width localparam rule (ADDR_WIDTH+1);
  - parameter legality checks (DEPTH 2..64, threshold ranges).
- One sub-module, srl_fifo_param_store: the pure shift-register array.
  - Ports: clk, we, addr, din, dout.
  - No reset.
- The top-level holds the count, rd_addr and flag logic.

Test Plan (DATA_WIDTH=8, DEPTH=4, AFULL_TH=3, AEMPTY_TH=1):
1. Reset, then push 0x11,0x22,0x33,0x44 on consecutive cycles:
   - if_empty_n=1 one cycle after the first push; if_dout=0x11;
   - if_almost_full=1 at count 3; if_full_n=0 at count 4; if_num_data_valid=4.
2. From full, push 0x55 with no pop:
   - ignored, count stays 4;
   - then pop 4 times -> if_dout sequence 0x11,0x22,0x33,0x44, then if_empty_n=0 and if_almost_empty=1.
3. With count=2 (0xA0,0xA1), push 0xA2 and pop in the same cycle:
   - count stays 2; if_dout changes 0xA0->0xA1; later pop yields 0xA2.
4. From full, push & pop in the same cycle:
   - count 4->3; pushed data not stored; if_full_n=1 next cycle.
5. Push with if_write_ce=0, and pop with if_read_ce=0 at count=2:
   - no state change; flags stable.
6. Assert reset mid-stream at count=3:
   - if_empty_n=0, if_full_n=1, if_num_data_valid=0 immediately (before the next clk edge);
   - a subsequent push of 0x77 -> if_dout=0x77.
   - With SRL_FIFO_PARAM_ERR_CHECK_EN: a pop while empty sets err_underflow=1, and it stays set until reset.
